// File: rtl/eq_pkg.sv
// Shared types and default constants for the LED level meter.
package eq_pkg;

   typedef enum logic {
      MODE_AUDIO = 1'b0,
      MODE_VOL   = 1'b1
   } mode_e;

   localparam int unsigned DEF_NUM_LEDS    = 8;
   localparam int unsigned DEF_HOLD_SMPLS  = 4800;
   localparam int unsigned DEF_DECAY_SMPLS = 480;
   localparam int unsigned DEF_DECAY_SHFT  = 3;

endpackage

// File: rtl/therm_enc.sv
// Level-to-thermometer encoder: segment k lit when level > k*step; also returns the lit count.
module therm_enc
   import eq_pkg::*;
#(
   parameter int unsigned NUM_LEDS = DEF_NUM_LEDS,
   parameter int unsigned LVL_W    = 15
) (
   input  logic [LVL_W-1:0]               level,
   input  logic [LVL_W-1:0]               step,
   output logic [NUM_LEDS-1:0]            therm_c,
   output logic [$clog2(NUM_LEDS+1)-1:0]  count_c
);

   localparam int unsigned CNT_W = $clog2(NUM_LEDS+1);

   always_comb begin
      therm_c = '0;
      count_c = '0;
      for (int k = 0; k < NUM_LEDS; k++) begin
         if (level > LVL_W'(k) * step) begin
            therm_c[k] = 1'b1;
            count_c    = count_c + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/led_level_meter.sv
// Stereo audio level meter / volume bar driving a NUM_LEDS segment display.
// Define PEAK_HOLD_EN to add the held peak dot on top of the audio bar.
module led_level_meter
   import eq_pkg::*;
#(
   parameter int unsigned NUM_LEDS    = DEF_NUM_LEDS,
   parameter int unsigned SMPL_W      = 16,
   parameter int unsigned VOL_W       = 12,
   parameter int unsigned HOLD_SMPLS  = DEF_HOLD_SMPLS,
   parameter int unsigned DECAY_SMPLS = DEF_DECAY_SMPLS,
   parameter int unsigned DECAY_SHFT  = DEF_DECAY_SHFT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     valid,
   input  logic signed [SMPL_W-1:0] lft_in,
   input  logic signed [SMPL_W-1:0] rht_in,
   input  logic [VOL_W-1:0]         vol,
   input  logic                     mode,
   output logic [NUM_LEDS-1:0]      LED
);

   localparam int unsigned AUD_W = SMPL_W - 1;
   localparam int unsigned CW    = $clog2(NUM_LEDS + 1);
   localparam int unsigned DW    = $clog2(DECAY_SMPLS + 1);
   localparam logic [AUD_W-1:0] AUD_STEP = AUD_W'((2 ** AUD_W) / NUM_LEDS);
   localparam logic [VOL_W-1:0] VOL_STEP = VOL_W'((2 ** VOL_W) / NUM_LEDS);

   mode_e              mode_q;
   logic               mode_chg_c;
   logic               aud_run_c;
   logic [AUD_W-1:0]   mag;
   logic [AUD_W-1:0]   mag_c;
   logic               vld1;
   logic               vld2;
   logic [AUD_W-1:0]   env;
   logic [AUD_W-1:0]   env_nxt_c;
   logic [AUD_W-1:0]   dec_c;
   logic [DW-1:0]      dcnt;
   logic [DW-1:0]      dcnt_nxt_c;
   logic [NUM_LEDS-1:0] aud_therm_c;
   logic [NUM_LEDS-1:0] vol_therm_c;
   logic [NUM_LEDS-1:0] dot_c;
   logic [CW-1:0]      aud_n_c;
   logic [CW-1:0]      vol_n_unused;

   // Absolute value; the most-negative code has no positive twin and saturates.
   function automatic logic [AUD_W-1:0] mag_of(input logic signed [SMPL_W-1:0] s);
      logic [SMPL_W-1:0] a;
      a = s[SMPL_W-1] ? SMPL_W'(-s) : SMPL_W'(s);
      return a[SMPL_W-1] ? {AUD_W{1'b1}} : a[AUD_W-1:0];
   endfunction

   always_comb begin
      mag_c      = (mag_of(lft_in) > mag_of(rht_in)) ? mag_of(lft_in) : mag_of(rht_in);
      mode_chg_c = (mode_e'(mode) != mode_q);
      aud_run_c  = (mode_e'(mode) == MODE_AUDIO) && !mode_chg_c;
   end

   // Envelope: instant attack, periodic proportional decay with a minimum step of 1.
   always_comb begin
      env_nxt_c  = env;
      dcnt_nxt_c = dcnt + DW'(1);
      dec_c      = env >> DECAY_SHFT;
      if (dec_c == '0) begin
         dec_c = AUD_W'(1);
      end
      if (mag > env) begin
         env_nxt_c  = mag;
         dcnt_nxt_c = '0;
      end else if (dcnt + DW'(1) == DW'(DECAY_SMPLS)) begin
         dcnt_nxt_c = '0;
         env_nxt_c  = (env > dec_c) ? env - dec_c : '0;
      end
   end

   therm_enc #(.NUM_LEDS(NUM_LEDS), .LVL_W(AUD_W)) u_aud_enc (
      .level   (env),
      .step    (AUD_STEP),
      .therm_c (aud_therm_c),
      .count_c (aud_n_c)
   );

   therm_enc #(.NUM_LEDS(NUM_LEDS), .LVL_W(VOL_W)) u_vol_enc (
      .level   (vol),
      .step    (VOL_STEP),
      .therm_c (vol_therm_c),
      .count_c (vol_n_unused)
   );

`ifdef PEAK_HOLD_EN
   localparam int unsigned HW = $clog2(HOLD_SMPLS + 1);

   logic [CW-1:0] p;
   logic [CW-1:0] p_nxt_c;
   logic [HW-1:0] hold;
   logic [HW-1:0] hold_nxt_c;

   // Peak follows the bar upward, then steps down one segment per expired hold period.
   always_comb begin
      p_nxt_c    = p;
      hold_nxt_c = hold;
      dot_c      = '0;
      if (aud_n_c >= p) begin
         p_nxt_c    = aud_n_c;
         hold_nxt_c = HW'(HOLD_SMPLS);
      end else if (hold == '0) begin
         p_nxt_c    = p - CW'(1);
         hold_nxt_c = HW'(HOLD_SMPLS);
      end else begin
         hold_nxt_c = hold - HW'(1);
      end
      for (int k = 0; k < NUM_LEDS; k++) begin
         dot_c[k] = (p_nxt_c == CW'(k + 1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p    <= '0;
         hold <= '0;
      end else if (!aud_run_c) begin
         p    <= '0;
         hold <= '0;
      end else if (vld2) begin
         p    <= p_nxt_c;
         hold <= hold_nxt_c;
      end
   end
`else
   logic [CW-1:0] aud_n_unused;

   assign aud_n_unused = aud_n_c;
   assign dot_c        = '0;
`endif

   // Audio pipeline: magnitude, envelope, LED; mode flips and volume mode hold it cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= MODE_AUDIO;
         mag    <= '0;
         vld1   <= 1'b0;
         vld2   <= 1'b0;
         env    <= '0;
         dcnt   <= '0;
         LED    <= '0;
      end else begin
         mode_q <= mode_e'(mode);
         if (!aud_run_c) begin
            mag  <= '0;
            vld1 <= 1'b0;
            vld2 <= 1'b0;
            env  <= '0;
            dcnt <= '0;
         end else begin
            vld1 <= valid;
            vld2 <= vld1;
            if (valid) begin
               mag <= mag_c;
            end
            if (vld1) begin
               env  <= env_nxt_c;
               dcnt <= dcnt_nxt_c;
            end
         end
         if (mode_e'(mode) == MODE_VOL) begin
            LED <= vol_therm_c;
         end else if (mode_chg_c) begin
            LED <= '0;
         end else if (vld2) begin
            LED <= aud_therm_c | dot_c;
         end
      end
   end

endmodule

// File: tb/tb_led_level_meter.sv
// Scoreboard bench for led_level_meter with short hold/decay periods.
module tb_led_level_meter;

   localparam int unsigned NUM_LEDS = 8;
   localparam int unsigned SMPL_W   = 16;
   localparam int unsigned VOL_W    = 12;

`ifdef PEAK_HOLD_EN
   localparam logic [7:0] EXP_032   = 8'h17;
   localparam logic [7:0] EXP_DECAY = 8'h03;
`else
   localparam logic [7:0] EXP_032   = 8'h07;
   localparam logic [7:0] EXP_DECAY = 8'h01;
`endif

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b1;
   logic                     valid = 1'b0;
   logic signed [SMPL_W-1:0] lft_in = '0;
   logic signed [SMPL_W-1:0] rht_in = '0;
   logic [VOL_W-1:0]         vol = '0;
   logic                     mode = 1'b0;
   logic [NUM_LEDS-1:0]      led;

   typedef struct {
      int unsigned due;
      logic [7:0]  exp;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   led_level_meter #(
      .NUM_LEDS(NUM_LEDS), .SMPL_W(SMPL_W), .VOL_W(VOL_W),
      .HOLD_SMPLS(4), .DECAY_SMPLS(2), .DECAY_SHFT(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .valid(valid), .lft_in(lft_in), .rht_in(rht_in),
      .vol(vol), .mode(mode), .LED(led)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: LED=%h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compare LED against every expectation that has come due.
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         check(e.name, led, e.exp);
      end
   end

   task automatic expect_at(input int unsigned d, input logic [7:0] e, input string n);
      sb.push_back('{cyc + d, e, n});
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input int l, input int r);
      lft_in = SMPL_W'(l);
      rht_in = SMPL_W'(r);
      valid  = 1'b1;
      tick(1);
      valid  = 1'b0;
      lft_in = '0;
      rht_in = '0;
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1 check("reset_led", led, 8'h00);
      tick(2);
      rst_n = 1'b1;
      tick(1);

      // first transaction: bar of 5, exact 3-clock latency
      expect_at(2, 8'h00, "latency_pre");
      expect_at(3, 8'h1F, "req031");
      pulse(16384, -20000);
      tick(4);
      expect_at(2, 8'h1F, "idle_static");
      tick(3);

      // two silent samples: one decay step to 10000
      expect_at(3, 8'h1F, "zero_first");
      pulse(0, 0);
      tick(1);
      expect_at(3, EXP_032, "req032");
      pulse(0, 0);
      tick(5);

      // asynchronous reset mid-hold
      #2 rst_n = 1'b0;
      #1 check("req035", led, 8'h00);
      tick(1);
      rst_n = 1'b1;
      tick(1);

      expect_at(2, 8'h00, "post_rst_pre");
      expect_at(3, 8'h1F, "post_rst");
      pulse(16384, -20000);
      tick(4);

      expect_at(3, 8'hFF, "req033");
      pulse(-32768, 0);
      tick(4);

      // volume bar mode
      mode = 1'b1;
      vol  = 12'd3000;
      expect_at(1, 8'h3F, "req034");
      tick(1);
      expect_at(3, 8'h3F, "vol_ignores_valid");
      pulse(30000, 30000);
      tick(3);
      vol = 12'd512;
      expect_at(1, 8'h01, "vol_512");
      tick(1);
      vol = 12'd513;
      expect_at(1, 8'h03, "vol_513");
      tick(1);
      vol = 12'd0;
      expect_at(1, 8'h00, "vol_0");
      tick(1);
      vol = 12'd4095;
      expect_at(1, 8'hFF, "vol_max");
      tick(1);

      mode = 1'b0;
      expect_at(1, 8'h00, "mode_clear");
      tick(3);

      // step boundaries and decay below the held peak
      expect_at(3, 8'h01, "step_equal");
      pulse(4096, 0);
      tick(1);
      expect_at(3, 8'h03, "step_above");
      pulse(0, 4097);
      tick(3);
      expect_at(3, 8'h03, "decay_wait");
      pulse(0, 0);
      tick(1);
      expect_at(3, EXP_DECAY, "decay_step");
      pulse(0, 0);
      tick(5);

      for (int i = 0; i < 20 && sb.size() > 0; i++) tick(1);
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_level_meter.md
LED_LEVEL_METER -- requirements
Module: led_level_meter

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8, number of LED segments (power of 2, 4..16).
REQ-002 SHALL have parameter SMPL_W, default 16, signed audio sample width.
REQ-003 SHALL have parameter VOL_W, default 12, unsigned volume pot width.
REQ-004 SHALL have parameter HOLD_SMPLS, default 4800, valid samples a peak dot is held before it steps down.
REQ-005 SHALL have parameter DECAY_SMPLS, default 480, valid samples between envelope decay steps.
REQ-006 SHALL have parameter DECAY_SHFT, default 3, right-shift used for the decay step.
REQ-007 Ports: clk input 1, system clock; rst_n input 1, reset.
REQ-008 Ports: valid input 1, one-clock strobe marking a new stereo sample.
REQ-009 Ports: lft_in input SMPL_W, signed left sample; rht_in input SMPL_W, signed right sample.
REQ-010 Ports: vol input VOL_W, volume pot value; mode input 1, 0 = audio meter, 1 = volume bar.
REQ-011 Ports: LED output NUM_LEDS, active-high registered LED drive.
REQ-012 One clock (clk); reset rst_n is asynchronous and active-low.

Function
REQ-013 Magnitude SHALL be max(|lft_in|,|rht_in|), SMPL_W-1 bits unsigned; most-negative input saturates to all-ones.
REQ-014 Magnitude SHALL be registered on the clk edge where valid=1 (stage 1).
REQ-015 Envelope env (SMPL_W-1 bits) SHALL update one clock after stage 1: instant attack, env <= mag when mag > env.
REQ-016 Otherwise, decay counter SHALL count valid samples; at DECAY_SMPLS it reloads and env <= env - max(env>>DECAY_SHFT, 1), floor 0.
REQ-017 Attack SHALL reload the decay counter; attack wins over a same-cycle decay.
REQ-018 Bar count n SHALL equal the number of k in 0..NUM_LEDS-1 with level > k*STEP, STEP = 2^(SMPL_W-1)/NUM_LEDS; LED[k] lit for k < n.
REQ-019 Peak index p (0..NUM_LEDS): when n >= p, p <= n and hold counter reloads HOLD_SMPLS.
REQ-020 Otherwise hold counter SHALL decrement per valid; at 0, p decrements by 1 (floor 0) and counter reloads.
REQ-021 In audio mode LED SHALL be bar OR peak dot (LED[p-1] when p>0), registered; total latency valid-to-LED = 3 clocks.
REQ-022 In volume mode LED[k] SHALL be lit iff vol > k*(2^VOL_W/NUM_LEDS), registered every clock (1-clock latency), valid ignored.
REQ-023 A change on mode SHALL clear env, p and all counters on the next clock; LED follows the new mode's rule.
REQ-024 Without valid pulses, audio-mode LED SHALL remain static.

Reset
REQ-025 rst_n low SHALL asynchronously clear LED, magnitude, env, p, decay and hold counters to 0.
REQ-026 Reset mid-decay or mid-hold SHALL abandon the pending step; first post-reset valid behaves as after power-up.

Configuration
REQ-027 Macro PEAK_HOLD_EN defined: peak index, hold counter and peak dot SHALL be implemented per REQ-019..021.
REQ-028 PEAK_HOLD_EN undefined: no peak logic SHALL be synthesised; audio-mode LED is the bar only.

Structure
REQ-029 Shared package eq_pkg SHALL hold mode enum (MODE_AUDIO, MODE_VOL) and default constants for NUM_LEDS, HOLD_SMPLS, DECAY_SMPLS, DECAY_SHFT.
REQ-030 Sub-module therm_enc SHALL convert a level plus step into the NUM_LEDS thermometer code and count n; instantiated for audio and volume paths.

Verification (NUM_LEDS=8, SMPL_W=16, VOL_W=12, HOLD_SMPLS=4, DECAY_SMPLS=2, DECAY_SHFT=1)
REQ-031 lft_in=16384, rht_in=-20000, one valid -> LED=8'h1F exactly 3 clocks later.
REQ-032 After REQ-031, two valids with zero samples -> env=10000, LED=8'h17 (bar 0x07 plus held dot LED[4]).
REQ-033 lft_in=-32768, rht_in=0, valid -> LED=8'hFF; no overflow to 0.
REQ-034 mode=1, vol=3000 -> LED=8'h3F one clock later; valid pulses have no effect.
REQ-035 rst_n asserted mid-hold with LED=8'h17 -> LED=8'h00 immediately, without a clock edge.
REQ-036 PEAK_HOLD_EN undefined, REQ-032 stimulus -> LED=8'h07.
